// File: rtl/rv32i_dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_mem_pkg
//  Description : Shared types and helpers for the RV32I data-memory
//                controller. Holds the access-size and FSM-state encodings,
//                the byte-enable generator and the alignment checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_mem_pkg;

    // Access size, same encoding as the core's store_size / load_size buses
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    // Lane enables for a store of the given size at byte offset addr_lo
    function automatic logic [3:0] byte_en(input mem_size_e size,
                                           input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            BYTE:    be = 4'b0001 << addr_lo;
            HALF:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
            WORD:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Reserved size counts as misaligned so one check covers both cases
    function automatic logic misaligned(input mem_size_e size,
                                        input logic [1:0] addr_lo);
        logic bad;
        case (size)
            BYTE:    bad = 1'b0;
            HALF:    bad = addr_lo[0];
            WORD:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_dmem_ctrl_if
//  Description : Core-to-data-memory request/acknowledge bus.
//                master = core side, slave = memory controller side.
//  Signals     : d_req, d_wr_en, dAddr[31:0], dWdata[31:0], store_size[1:0],
//                load_size[1:0], load_unsigned      (master -> slave)
//                busy, d_ack, d_err, dRdata[31:0]   (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rv32i_dmem_ctrl_if;

    logic        d_req;
    logic        d_wr_en;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [1:0]  store_size;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic        busy;
    logic        d_ack;
    logic        d_err;
    logic [31:0] dRdata;

    modport master (
        output d_req, d_wr_en, dAddr, dWdata, store_size, load_size, load_unsigned,
        input  busy, d_ack, d_err, dRdata
    );

    modport slave (
        input  d_req, d_wr_en, dAddr, dWdata, store_size, load_size, load_unsigned,
        output busy, d_ack, d_err, dRdata
    );

endinterface
`default_nettype wire

// File: rtl/rv32i_dmem_ctrl_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_load_align
//  Description : Combinational load aligner. Picks the addressed byte/half
//                out of a raw array word and sign- or zero-extends it.
//  Ports       : raw_i[31:0]   raw word read from the array
//                addr_lo_i[1:0] byte offset within the word
//                size_i[1:0]   access size (mem_size_e encoding)
//                unsigned_i    1 = zero-extend, 0 = sign-extend
//                data_o[31:0]  extended load result (0 for reserved size)
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_load_align
    import rv32i_mem_pkg::*;
(
    input  wire [31:0] raw_i,
    input  wire [1:0]  addr_lo_i,
    input  wire [1:0]  size_i,
    input  wire        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        ext_b;
    logic        ext_h;

    always_comb begin
        sel_byte = raw_i[8*addr_lo_i +: 8];
        sel_half = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
        ext_b    = sel_byte[7] & ~unsigned_i;
        ext_h    = sel_half[15] & ~unsigned_i;
        data_o   = '0;
        case (mem_size_e'(size_i))
            BYTE:    data_o = {{24{ext_b}}, sel_byte};
            HALF:    data_o = {{16{ext_h}}, sel_half};
            WORD:    data_o = raw_i;
            default: data_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_dmem_ctrl
//  Description : Data-memory controller with req/ack handshake, programmable
//                wait states, byte-enabled stores, sign/zero-extended loads
//                and error reporting (misaligned, reserved size, out of range).
//  Ports       : clk   system clock (rising edge)
//                rst   asynchronous active-high reset
//                bus   rv32i_dmem_ctrl_if.slave - core request/response bus
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_dmem_ctrl
    import rv32i_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  wire              clk,
    input  wire              rst,
    rv32i_dmem_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    dmem_state_e     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            accept;

    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    mem_size_e       size_q;
    logic            uns_q;
    logic            wr_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    mem_size_e       req_size;
    logic [31:0]     src_addr;
    logic [31:0]     src_wdata;
    mem_size_e       src_size;
    logic            src_uns;
    logic            src_wr;

    logic [31:0]     offset;
    logic [IDX_W-1:0] idx;
    logic            acc_err;
    logic [3:0]      be;
    logic [31:0]     wdata_rep;
    logic            we;
    logic [31:0]     raw_word;
    logic [31:0]     load_data;

    assign req_size = bus.d_wr_en ? mem_size_e'(bus.store_size)
                                  : mem_size_e'(bus.load_size);

    // With no wait states RESP is entered on the very edge that accepts the
    // request, so the access must be served straight from the bus; otherwise
    // it is served from the fields captured at acceptance.
    assign src_addr  = (WAIT_STATES == 0) ? bus.dAddr         : addr_q;
    assign src_wdata = (WAIT_STATES == 0) ? bus.dWdata        : wdata_q;
    assign src_size  = (WAIT_STATES == 0) ? req_size          : size_q;
    assign src_uns   = (WAIT_STATES == 0) ? bus.load_unsigned : uns_q;
    assign src_wr    = (WAIT_STATES == 0) ? bus.d_wr_en       : wr_q;

    // Addresses below BASE wrap to a huge offset and fail the range test
    assign offset  = src_addr - BASE_ADDR;
    assign idx     = offset[IDX_W+1:2];
    assign acc_err = misaligned(src_size, src_addr[1:0]) || ({1'b0, offset} >= SPAN);
    assign be      = byte_en(src_size, src_addr[1:0]);

    always_comb begin
        case (src_size)
            BYTE:    wdata_rep = {4{src_wdata[7:0]}};
            HALF:    wdata_rep = {2{src_wdata[15:0]}};
            default: wdata_rep = src_wdata;
        endcase
    end

    // Every transition into RESP is a fresh access, so the commit happens
    // exactly on RESP entry; a store still in WAIT when reset hits never
    // reaches this point.
    assign we = (state_d == RESP) && src_wr && !acc_err;

    // ------------------------------------------------------------------
    // Array: four byte lanes with independent write enables
    // ------------------------------------------------------------------
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] lane_q [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (we && be[l]) begin
                lane_q[idx] <= wdata_rep[8*l +: 8];
            end
        end

        assign raw_word[8*l +: 8] = lane_q[idx];
    end

    rv32i_load_align u_align (
        .raw_i      (raw_word),
        .addr_lo_i  (src_addr[1:0]),
        .size_i     (src_size),
        .unsigned_i (src_uns),
        .data_o     (load_data)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (bus.d_req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= BYTE;
            uns_q   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.dAddr;
                wdata_q <= bus.dWdata;
                size_q  <= req_size;
                uns_q   <= bus.load_unsigned;
                wr_q    <= bus.d_wr_en;
            end
            // Response fields live for the RESP cycle only
            if (state_d == RESP) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || src_wr) ? 32'h0 : load_data;
            end else begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.d_ack  = (state_q == RESP);
    assign bus.d_err  = err_q;
    assign bus.dRdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_dmem_ctrl
//  Description : Directed bench for rv32i_dmem_ctrl. Three instances share
//                clk/rst: port 0 with 0 wait states, port 1 with 1, port 2
//                with 3. Expected values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_dmem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  req, wr, uns;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [1:0]  ssz   [3];
    logic [1:0]  lsz   [3];
    logic [2:0]  busy, ack, err;
    logic [31:0] rdata [3];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        rv32i_dmem_ctrl_if bus ();
        assign bus.d_req         = req[k];
        assign bus.d_wr_en       = wr[k];
        assign bus.dAddr         = addr[k];
        assign bus.dWdata        = wdata[k];
        assign bus.store_size    = ssz[k];
        assign bus.load_size     = lsz[k];
        assign bus.load_unsigned = uns[k];
        assign busy[k]           = bus.busy;
        assign ack[k]            = bus.d_ack;
        assign err[k]            = bus.d_err;
        assign rdata[k]          = bus.dRdata;

        rv32i_dmem_ctrl #(
            .DEPTH_WORDS (256),
            .WAIT_STATES ((k == 0) ? 0 : ((k == 1) ? 1 : 3)),
            .BASE_ADDR   (32'h0000_0000)
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // One complete access on port k; req dropped right after acceptance
    task automatic access(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz, input logic u,
                          input logic exp_err, input logic [31:0] exp_data,
                          input string tag);
        int cyc;
        @(negedge clk);
        req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d; uns[k] = u;
        ssz[k] = w ? sz : 2'b11;
        lsz[k] = w ? 2'b11 : sz;
        @(posedge clk); #1;
        req[k] = 1'b0;
        cyc = 1;
        while (!ack[k] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " lat"},  cyc,      lat_of(k));
        chk({tag, " err"},  err[k],   exp_err);
        chk({tag, " data"}, rdata[k], exp_data);
        @(posedge clk); #1;
        chk({tag, " ack drop"},  ack[k],   1'b0);
        chk({tag, " data drop"}, rdata[k], 32'h0);
    endtask

    initial begin
        int cyc;
        req = '0; wr = '0; uns = '0;
        for (int k = 0; k < 3; k++) begin
            addr[k] = '0; wdata[k] = '0; ssz[k] = 2'b10; lsz[k] = 2'b10;
        end

        // ---------------- reset values ----------------
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst busy%0d", k),  busy[k],  1'b0);
            chk($sformatf("rst ack%0d", k),   ack[k],   1'b0);
            chk($sformatf("rst err%0d", k),   err[k],   1'b0);
            chk($sformatf("rst rdata%0d", k), rdata[k], 32'h0);
        end
        rst = 1'b0;

        // ---------------- port 0: no wait states ----------------
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 32'h0,        "sw 10");
        access(0, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 1'b0, 32'hDEADBEEF, "lw 10");
        access(0, 1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, 1'b0, 32'h0,        "sb 13");
        access(0, 1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 1'b0, 32'hFFFFFF80, "lb 13");
        access(0, 1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 1'b0, 32'h00000080, "lbu 13");
        access(0, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 1'b0, 32'h80ADBEEF, "lw 10 b");
        access(0, 1'b0, 32'h12, 32'h0,        2'b01, 1'b0, 1'b0, 32'hFFFF80AD, "lh 12");
        access(0, 1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 1'b0, 32'h000080AD, "lhu 12");
        access(0, 1'b0, 32'h10, 32'h0,        2'b00, 1'b0, 1'b0, 32'hFFFFFFEF, "lb 10");

        // ---------------- errors ----------------
        access(0, 1'b1, 32'h00, 32'h11223344, 2'b10, 1'b0, 1'b0, 32'h0,        "sw 00");
        access(0, 1'b0, 32'h11, 32'h0,        2'b10, 1'b0, 1'b1, 32'h0,        "lw mis");
        access(0, 1'b1, 32'h01, 32'h0000AAAA, 2'b01, 1'b0, 1'b1, 32'h0,        "sh mis");
        access(0, 1'b0, 32'h00, 32'h0,        2'b10, 1'b0, 1'b0, 32'h11223344, "lw 00 a");
        access(0, 1'b1, 32'h10, 32'hFFFFFFFF, 2'b11, 1'b0, 1'b1, 32'h0,        "s rsvd");
        access(0, 1'b0, 32'h10, 32'h0,        2'b11, 1'b0, 1'b1, 32'h0,        "l rsvd");
        access(0, 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 1'b0, 32'h80ADBEEF, "lw 10 c");
        access(0, 1'b1, 32'h400, 32'h99999999, 2'b10, 1'b0, 1'b1, 32'h0,       "sw oor");
        access(0, 1'b0, 32'h400, 32'h0,       2'b10, 1'b0, 1'b1, 32'h0,        "lw oor");
        access(0, 1'b0, 32'h00, 32'h0,        2'b10, 1'b0, 1'b0, 32'h11223344, "lw 00 b");

        // ---------------- reset during RESP ----------------
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h10; lsz[0] = 2'b10; ssz[0] = 2'b11;
        @(posedge clk); #1;
        req[0] = 1'b0;
        chk("rr ack", ack[0], 1'b1);
        chk("rr data", rdata[0], 32'h80ADBEEF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rr rst ack", ack[0], 1'b0);
        chk("rr rst data", rdata[0], 32'h0);
        chk("rr rst busy", busy[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- port 2: 3 wait states ----------------
        access(2, 1'b1, 32'h10, 32'hCAFE1234, 2'b10, 1'b0, 1'b0, 32'h0, "ws3 sw 10");
        @(negedge clk);
        req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h12; lsz[2] = 2'b01; ssz[2] = 2'b11; uns[2] = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("hold busy c%0d", i), busy[2], 1'b1);
            chk($sformatf("hold ack c%0d", i),  ack[2],  1'b0);
            if (i == 1) begin
                // request fields change while WAIT must ignore them
                @(negedge clk);
                addr[2] = 32'h10; lsz[2] = 2'b10;
            end
            @(posedge clk); #1;
        end
        chk("hold ack", ack[2], 1'b1);
        chk("hold busy", busy[2], 1'b1);
        chk("hold data", rdata[2], 32'hFFFFCAFE);
        @(posedge clk); #1;
        req[2] = 1'b0;
        cyc = 1;
        while (!ack[2] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("2nd lat", cyc, 32'd4);
        chk("2nd data", rdata[2], 32'hCAFE1234);
        @(posedge clk); #1;
        chk("2nd idle", busy[2], 1'b0);

        // ---------------- reset while store in WAIT ----------------
        access(2, 1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0, 32'h0, "ws3 sw 20");
        @(negedge clk);
        req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h12345678;
        ssz[2] = 2'b10; lsz[2] = 2'b11;
        @(posedge clk); #1;
        req[2] = 1'b0;
        chk("rw busy", busy[2], 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw rst busy", busy[2], 1'b0);
        chk("rw rst ack", ack[2], 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        access(2, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, 32'hCAFEF00D, "ws3 lw 20");

        // ---------------- port 1: back-to-back loads ----------------
        access(1, 1'b1, 32'h30, 32'hA0A0A0A0, 2'b10, 1'b0, 1'b0, 32'h0, "b2b pre0");
        access(1, 1'b1, 32'h34, 32'hB1B1B1B1, 2'b10, 1'b0, 1'b0, 32'h0, "b2b pre1");
        access(1, 1'b1, 32'h38, 32'hC2C2C2C2, 2'b10, 1'b0, 1'b0, 32'h0, "b2b pre2");
        access(1, 1'b1, 32'h3C, 32'hD3D3D3D3, 2'b10, 1'b0, 1'b0, 32'h0, "b2b pre3");
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h30; lsz[1] = 2'b10; ssz[1] = 2'b11;
        @(posedge clk); #1;
        cyc = 1;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] expv;
            expv = (i == 0) ? 32'hA0A0A0A0 : (i == 1) ? 32'hB1B1B1B1 :
                   (i == 2) ? 32'hC2C2C2C2 : 32'hD3D3D3D3;
            while (!ack[1] && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk($sformatf("b2b lat%0d", i),  cyc,      32'd2);
            chk($sformatf("b2b data%0d", i), rdata[1], expv);
            @(negedge clk);
            if (i < 3) addr[1] = 32'h30 + 32'(4 * (i + 1));
            else       req[1]  = 1'b0;
            @(posedge clk); #1;
            cyc = 1;
        end
        chk("b2b idle", busy[1], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_dmem_ctrl.md
# rv32i_dmem_ctrl

Parametrised data-memory controller that replaces the single-cycle, always-ready data memory beside `cpu_core`. It adds a request/acknowledge handshake, configurable wait states, byte/half/word stores with byte enables, and signed or unsigned sub-word loads. It also reports misaligned, out-of-range and reserved-size accesses. It sits between the core's data port and the data RAM array inside the RV32I top level.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words in the array; power of two, ≥4.
- `WAIT_STATES`, 0: extra cycles between request acceptance and response; 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `d_req`  in  1  access request; sampled only when `busy`=0 or `d_ack`=1.
- `d_wr_en`  in  1  1 = store, 0 = load; qualified by `d_req`.
- `dAddr`  in  32  byte address.
- `dWdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `store_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `load_size`  in  2  same encoding as `store_size`.
- `load_unsigned`  in  1  1 = zero-extend sub-word loads (LBU/LHU), 0 = sign-extend.
- `busy`  out  1  a request is in flight.
- `d_ack`  out  1  one-cycle response strobe.
- `d_err`  out  1  valid with `d_ack`; access was rejected.
- `dRdata`  out  32  load result, valid with `d_ack`; 0 for stores and errors.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**: when `d_req`=1, capture addr, wdata, size, unsigned and wr_en. Go to WAIT if WAIT_STATES>0, otherwise RESP.
- **WAIT**: a down-counter loaded with WAIT_STATES-1 decrements each cycle. At 0, go to RESP.
- **Entering RESP**:
  - Perform the array write (stores) or the array read (loads).
  - Assert `d_ack` for exactly the RESP cycle.
  - Drive `dRdata` and `d_err` for the RESP cycle only; both return to 0 after it.
- **RESP**: if `d_req`=1, accept a new request exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- `d_req` in WAIT, or in RESP's cycle predecessor, is ignored. The core holds `d_req` until `d_ack`.
- Word index = (`dAddr`-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
- Store byte enables: byte → 1 lane at addr[1:0]; half → lanes {addr[1],0} and {addr[1],1}; word → all 4 lanes. Data is replicated to the selected lanes.
- Load: select the lane(s) by addr[1:0], then sign- or zero-extend per `load_unsigned`. Word loads ignore `load_unsigned`.
- An access is an error (`d_err`=1, no write, `dRdata`=0) when any of these holds:
  - size = 11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4).
- Error latency equals normal latency.
- Array contents are not cleared by reset; initial contents are undefined (the bench preloads).

## Timing
- Reset values: `busy`=0, `d_ack`=0, `d_err`=0, `dRdata`=0, FSM=IDLE, counter=0.
- Latency: request sampled at edge N → `d_ack` high in cycle N+WAIT_STATES+1.
- Peak throughput: one access per WAIT_STATES+1 cycles, using back-to-back acceptance in RESP.
- `busy`=1 in WAIT and RESP. In IDLE on the cycle of acceptance, `busy` rises the following cycle.
- Reset asserted mid-operation (WAIT or RESP): a pending store is discarded and never written; outputs go to reset values immediately (asynchronous).
- A write and a following read to the same word return the new data; there is no bypass hazard because the write commits on RESP entry.
- Counter width: 4 bits. WAIT_STATES=0 generates no WAIT state.

## Structure
- Package `rv32i_mem_pkg`:
  - `mem_size_e` enum (BYTE, HALF, WORD, RSVD);
  - `dmem_state_e` enum;
  - a function computing the 4-bit byte-enable from size and addr[1:0];
  - a misalignment-check function.
- One combinational sub-module, `rv32i_load_align`: takes the raw word, addr[1:0], size and unsigned flag, and produces the extended 32-bit result.
- The array is inferred as 4 byte-wide lanes with per-lane write enables.

## Test plan
- WAIT_STATES=0: SW 0xDEADBEEF @0x10, then LW @0x10 → `d_ack` one cycle after each request, `dRdata`=0xDEADBEEF, `d_err`=0.
- SB 0x80 @0x13, then LB @0x13 → 0xFFFFFF80; LBU → 0x00000080; LW @0x10 → 0x80ADBEEF.
- WAIT_STATES=3: LH @0x12 → `d_ack` exactly 4 cycles after acceptance with `busy`=1 throughout; a second `d_req` held during WAIT is ignored until RESP.
- Errors: LW @0x11, SH @0x01, size 11, and address BASE+DEPTH_WORDS*4 → `d_ack` with `d_err`=1 and `dRdata`=0; a following LW shows the word unchanged.
- Reset pulse while a SW 0x12345678 @0x20 is in WAIT → outputs zero immediately; a subsequent LW @0x20 returns the preloaded value.
- Back-to-back: `d_req` held high over 4 loads with WAIT_STATES=1 → one `d_ack` every 2 cycles, in order.
